maze_map_writer: RTL and testbench

MAZE_MAP_WRITER -- requirements
Module: maze_map_writer

---
 rtl/maze_map_writer.sv | 131 +++++++++++++
 tb/tb_maze_map_writer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/maze_map_writer.sv
// Loads one maze (12/24/30 rows, column-masked) from a row ROM into a flat map for the drawer.
// Define MAZE_DOUBLE_BUFFER_EN to load into a shadow buffer copied out on the next frame boundary.
module maze_map_writer #(
  parameter int unsigned ROW_W = 40,
  parameter int unsigned ROWS  = 30
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Load,
  input  logic [1:0]            i_MazeLevel,
  output logic [6:0]            o_RomAddr,
  input  logic [ROW_W-1:0]      i_RomData,
  input  logic                  i_FrameDone,
  output logic [ROW_W*ROWS-1:0] o_MazeMap,
  output logic                  o_Busy,
  output logic                  o_MapValid,
  output logic                  o_Error
);

  typedef enum logic [1:0] {StIdle, StClear, StRead, StDone} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              level_q;
  logic [4:0]              row_q;
  logic [4:0]              wr_row;
  logic [4:0]              n_rows;
  int unsigned             n_cols;
  logic [ROW_W-1:0]        col_mask;
  logic [6:0]              addr_q;
  logic                    err_q;
  logic                    valid_q;
  logic [ROW_W*ROWS-1:0]   buf_q;
  logic                    accept, load_ok, last_read;

  always_comb begin
    accept    = i_Load && (state_q == StIdle || state_q == StDone);
    load_ok   = accept && (i_MazeLevel != 2'b11);
    wr_row    = row_q - 5'd1;
    unique case (level_q)
      2'b00:   begin n_rows = 5'd12; n_cols = 16; end
      2'b01:   begin n_rows = 5'd24; n_cols = 32; end
      default: begin n_rows = 5'd30; n_cols = 40; end
    endcase
    last_read = (state_q == StRead) && (row_q == n_rows);
    col_mask  = '0;
    for (int unsigned i = 0; i < ROW_W; i++) col_mask[i] = (i < n_cols);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (load_ok) state_d = StClear;
      StClear:        state_d = StRead;
      StRead:         if (row_q == n_rows) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  // READ cycle k addresses row k (k < N) and captures row k-1 from the ROM word.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      level_q <= 2'b00;
      row_q   <= 5'd0;
      addr_q  <= 7'd0;
      err_q   <= 1'b0;
      buf_q   <= '0;
    end else begin
      err_q <= accept && (i_MazeLevel == 2'b11);
      if (load_ok) level_q <= i_MazeLevel;
      case (state_q)
        StClear: begin
          buf_q  <= '0;
          row_q  <= 5'd0;
          addr_q <= {level_q, 5'd0};
        end
        StRead: begin
          if (row_q != 5'd0) buf_q[wr_row*ROW_W +: ROW_W] <= i_RomData & col_mask;
          if ((row_q + 5'd1) < n_rows) addr_q <= {level_q, row_q + 5'd1};
          row_q <= row_q + 5'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef MAZE_DOUBLE_BUFFER_EN
  logic                  pending_q;
  logic [ROW_W*ROWS-1:0] map_q;

  // Pending is only set at DONE entry, so a frame pulse on the final capture cycle cannot copy.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      pending_q <= 1'b0;
      map_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      if (i_FrameDone && pending_q) begin
        map_q   <= buf_q;
        valid_q <= 1'b1;
      end
      if (load_ok)                         pending_q <= 1'b0;
      else if (last_read)                  pending_q <= 1'b1;
      else if (i_FrameDone && pending_q)   pending_q <= 1'b0;
    end
  end

  assign o_MazeMap = map_q;
`else
  logic unused_frame_done;
  assign unused_frame_done = i_FrameDone;

  always_ff @(posedge i_Clk) begin
    if (i_Rst)          valid_q <= 1'b0;
    else if (load_ok)   valid_q <= 1'b0;
    else if (last_read) valid_q <= 1'b1;
  end

  assign o_MazeMap = buf_q;
`endif

  assign o_RomAddr  = addr_q;
  assign o_Busy     = (state_q == StClear) || (state_q == StRead);
  assign o_MapValid = valid_q;
  assign o_Error    = err_q;

endmodule

// File: tb/tb_maze_map_writer.sv
// Randomized bench for maze_map_writer: a ROM model feeds the DUT, a row-level model predicts the map.
module tb_maze_map_writer;
  localparam int ROW_W = 40;
  localparam int ROWS  = 30;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  load;
  logic [1:0]            lvl;
  logic [6:0]            addr;
  logic [ROW_W-1:0]      rom_data;
  logic                  frame_done;
  logic [ROW_W*ROWS-1:0] maze_map;
  logic                  busy, map_valid, err;

  logic [ROW_W-1:0] rom [128];
  logic [ROW_W-1:0] vis_exp [ROWS];
  logic             vis_valid;
  int               n_cmp = 0;
  int               n_bad = 0;

  always #5 clk = ~clk;

  // Synchronous ROM: word for the address seen at an edge is presented for the following cycle.
  always @(posedge clk) rom_data <= rom[addr];

  maze_map_writer #(.ROW_W(ROW_W), .ROWS(ROWS)) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Load      (load),
    .i_MazeLevel (lvl),
    .o_RomAddr   (addr),
    .i_RomData   (rom_data),
    .i_FrameDone (frame_done),
    .o_MazeMap   (maze_map),
    .o_Busy      (busy),
    .o_MapValid  (map_valid),
    .o_Error     (err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rows_of(input logic [1:0] l);
    return (l == 2'd0) ? 12 : (l == 2'd1) ? 24 : 30;
  endfunction

  function automatic int cols_of(input logic [1:0] l);
    return (l == 2'd0) ? 16 : (l == 2'd1) ? 32 : 40;
  endfunction

  task automatic check_map(input string tag);
    for (int r = 0; r < ROWS; r++)
      check($sformatf("%s row%0d", tag, r), 64'(maze_map[r*ROW_W +: ROW_W]), 64'(vis_exp[r]));
    check({tag, " valid"}, 64'(map_valid), 64'(vis_valid));
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 128; i++) rom[i] = ROW_W'({$urandom, $urandom});
  endtask

  task automatic do_load(input logic [1:0] l, input bit fd_on_last);
    int               n;
    int               busy_cnt;
    logic [63:0]      mask;
    logic [ROW_W-1:0] new_map [ROWS];
    n        = rows_of(l);
    busy_cnt = 0;
    mask     = (64'd1 << cols_of(l)) - 64'd1;
    for (int r = 0; r < ROWS; r++)
      new_map[r] = (r < n) ? ROW_W'(64'(rom[{l, 5'(r)}]) & mask) : '0;
    @(negedge clk);
    load = 1'b1;
    lvl  = l;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      load       = 1'b0;
      frame_done = 1'b0;
      lvl        = 2'($urandom);
      if (!busy) break;
      busy_cnt++;
      if (busy_cnt >= 2 && busy_cnt <= n + 1)
        check($sformatf("rom_addr L%0d", l), 64'(addr), 64'({l, 5'(busy_cnt - 2)}));
`ifdef MAZE_DOUBLE_BUFFER_EN
      check("valid_hold", 64'(map_valid), 64'(vis_valid));
`else
      check("valid_low", 64'(map_valid), 64'd0);
`endif
      load = ($urandom_range(0, 3) == 0);
      if (fd_on_last && busy_cnt == n + 2) frame_done = 1'b1;
    end
    load       = 1'b0;
    frame_done = 1'b0;
    check($sformatf("busy_cycles L%0d", l), 64'(busy_cnt), 64'(n + 2));
    check("addr_hold", 64'(addr), 64'({l, 5'(n - 1)}));
`ifdef MAZE_DOUBLE_BUFFER_EN
    repeat (2) @(negedge clk);
    check_map("before_frame");
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
`endif
    for (int r = 0; r < ROWS; r++) vis_exp[r] = new_map[r];
    vis_valid = 1'b1;
    check_map($sformatf("map L%0d", l));
  endtask

  initial begin
    int  cnt;
    bit  seen;
    rst        = 1'b1;
    load       = 1'b0;
    lvl        = 2'd0;
    frame_done = 1'b0;
    vis_valid  = 1'b0;
    for (int r = 0; r < ROWS; r++) vis_exp[r] = '0;
    fill_rom();
    repeat (3) @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst err", 64'(err), 64'd0);
    check("rst addr", 64'(addr), 64'd0);
    check_map("rst");
    rst = 1'b0;

    do_load(2'd0, 1'b0);

    for (int r = 0; r < 32; r++) rom[64 + r] = '1;
    do_load(2'd2, 1'b1);
    check("hard all ones row29", 64'(maze_map[29*ROW_W +: ROW_W]), 64'hFF_FFFF_FFFF);

    // Invalid level: one error pulse, nothing else moves.
    @(negedge clk);
    load = 1'b1;
    lvl  = 2'd3;
    @(negedge clk);
    load = 1'b0;
    check("err pulse", 64'(err), 64'd1);
    check("err busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("err cleared", 64'(err), 64'd0);
    check("err busy2", 64'(busy), 64'd0);
    check_map("after err");

    do_load(2'd0, 1'b0);
    for (int it = 0; it < 6; it++) begin
      fill_rom();
      do_load(2'($urandom_range(0, 2)), 1'($urandom));
    end
    do_load(2'd1, 1'b1);

    // Reset while row 5 of a Normal load is addressed.
    fill_rom();
    @(negedge clk);
    load = 1'b1;
    lvl  = 2'd1;
    cnt  = 0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      load = 1'b0;
      if (busy) cnt++;
      if (cnt == 7) begin
        seen = 1'b1;
        break;
      end
    end
    check("reached row5", 64'(seen), 64'd1);
    check("row5 addr", 64'(addr), 64'h25);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort err", 64'(err), 64'd0);
    check("abort addr", 64'(addr), 64'd0);
    for (int r = 0; r < ROWS; r++) vis_exp[r] = '0;
    vis_valid = 1'b0;
    check_map("abort");
    repeat (3) @(negedge clk);
    check("abort stays idle", 64'(busy), 64'd0);
    check("abort no valid", 64'(map_valid), 64'd0);

    do_load(2'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
